// File: rtl/crystal_power_sequencer_pkg.sv
// Shared types and constants for the crystal power sequencer and its neighbours.
package crystal_pkg;

  localparam int unsigned NUM_CRYSTALS = 8;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned MAP_W        = 4 * NUM_CRYSTALS;

  // Probe result for a crystal whose link could not be determined.
  localparam logic [3:0] CRYSTAL_BAD = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StUpStep,
    StUpDwell,
    StOn,
    StDnStep,
    StDnDwell,
    StError
  } seq_state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_NO_MAP  = 3'd1,
    ERR_BAD_MAP = 3'd2,
    ERR_LOOP    = 3'd3,
    ERR_ABORT   = 3'd4
  } err_code_e;

  // Link nibble of crystal idx within a packed chain map.
  function automatic logic [3:0] map_entry(input logic [MAP_W-1:0] map,
                                           input logic [IDX_W-1:0] idx);
    return map[{idx, 2'b00} +: 4];
  endfunction

  // Any link with the top bit set (CRYSTAL_BAD included) points at no crystal.
  function automatic logic link_broken(input logic [3:0] link);
    return link[3] == CRYSTAL_BAD[3];
  endfunction

endpackage

// File: rtl/crystal_power_sequencer_if.sv
// Control/status bundle between a supervisor and the crystal power sequencer.
interface crystal_power_sequencer_if;
  import crystal_pkg::*;

  logic                    start;
  logic                    stop;
  logic                    abort;
  logic                    clear_err;
  logic                    map_valid;
  logic [MAP_W-1:0]        crystal_map;
  logic [NUM_CRYSTALS-1:0] power_en;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [2:0]              err_code;
  logic [IDX_W-1:0]        step_idx;

  modport master (
    output start, stop, abort, clear_err, map_valid, crystal_map,
    input  power_en, busy, done, err, err_code, step_idx
  );

  modport slave (
    input  start, stop, abort, clear_err, map_valid, crystal_map,
    output power_en, busy, done, err, err_code, step_idx
  );

endinterface

// File: rtl/crystal_dwell_timer.sv
// Clearable up-counter that flags the last cycle of a DWELL_COUNT-long dwell.
module crystal_dwell_timer #(
  parameter int unsigned        TIMER_W     = 20,
  parameter logic [TIMER_W-1:0] DWELL_COUNT = TIMER_W'(50000)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  // Clear wins over count; otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_i) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == DWELL_COUNT - TIMER_W'(1));

endmodule

// File: rtl/crystal_power_sequencer.sv
// Powers the crystals up one at a time along the probed chain, and back down in reverse.
module crystal_power_sequencer
  import crystal_pkg::*;
#(
  parameter int unsigned        TIMER_W     = 20,
  parameter logic [TIMER_W-1:0] DWELL_COUNT = TIMER_W'(50000)
) (
  input  logic                       system_clk,
  input  logic                       rst_n,
  crystal_power_sequencer_if.slave   seq_if
);

  seq_state_e                         state_q, state_d;
  logic [MAP_W-1:0]                   map_q, map_d;
  logic [NUM_CRYSTALS-1:0]            visited_q, visited_d;
  logic [NUM_CRYSTALS-1:0]            power_en_q, power_en_d;
  logic [NUM_CRYSTALS-1:0][IDX_W-1:0] order_q, order_d;
  logic [IDX_W-1:0]                   cur_q, cur_d;
  logic [IDX_W-1:0]                   step_q, step_d;
  logic                               done_q, done_d;
  err_code_e                          err_code_q, err_code_d;

  logic       timer_clear;
  logic       timer_count;
  logic       timer_expired;
  logic [3:0] nxt;

  assign nxt = map_entry(map_q, cur_q);

  crystal_dwell_timer #(
    .TIMER_W     (TIMER_W),
    .DWELL_COUNT (DWELL_COUNT)
  ) u_dwell_timer (
    .clk_i     (system_clk),
    .rst_ni    (rst_n),
    .clear_i   (timer_clear),
    .count_i   (timer_count),
    .expired_o (timer_expired)
  );

  // Next-state logic: walk the chain up, hold, unwind the recorded order down.
  always_comb begin
    state_d     = state_q;
    map_d       = map_q;
    visited_d   = visited_q;
    power_en_d  = power_en_q;
    order_d     = order_q;
    cur_d       = cur_q;
    step_d      = step_q;
    done_d      = 1'b0;
    err_code_d  = err_code_q;
    timer_clear = 1'b0;
    timer_count = 1'b0;

    case (state_q)
      StIdle: begin
        if (seq_if.start) begin
          if (seq_if.map_valid) begin
            map_d     = seq_if.crystal_map;
            cur_d     = '0;
            step_d    = '0;
            visited_d = '0;
            state_d   = StUpStep;
          end else begin
            err_code_d = ERR_NO_MAP;
            state_d    = StError;
          end
        end
      end
      StUpStep: begin
        if (visited_q[cur_q]) begin
          power_en_d = '0;
          err_code_d = ERR_LOOP;
          state_d    = StError;
        end else begin
          power_en_d[cur_q] = 1'b1;
          visited_d[cur_q]  = 1'b1;
          order_d[step_q]   = cur_q;
          timer_clear       = 1'b1;
          state_d           = StUpDwell;
        end
      end
      StUpDwell: begin
        timer_count = 1'b1;
        if (timer_expired) begin
          if (step_q == 3'd7) begin
            done_d  = 1'b1;
            state_d = StOn;
          end else if (link_broken(nxt)) begin
            power_en_d = '0;
            err_code_d = ERR_BAD_MAP;
            state_d    = StError;
          end else begin
            cur_d   = nxt[IDX_W-1:0];
            step_d  = step_q + 3'd1;
            state_d = StUpStep;
          end
        end
      end
      StOn: begin
        if (seq_if.stop) begin
          step_d  = 3'd7;
          state_d = StDnStep;
        end
      end
      StDnStep: begin
        power_en_d[order_q[step_q]] = 1'b0;
        timer_clear                 = 1'b1;
        state_d                     = StDnDwell;
      end
      StDnDwell: begin
        timer_count = 1'b1;
        if (timer_expired) begin
          if (step_q == 3'd0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            step_d  = step_q - 3'd1;
            state_d = StDnStep;
          end
        end
      end
      StError: begin
        if (seq_if.clear_err) begin
          err_code_d = ERR_NONE;
          state_d    = StIdle;
        end
      end
      default: begin
        power_en_d = '0;
        state_d    = StIdle;
      end
    endcase

    // Abort overrides everything, but only while a sequence is live or holding.
    if (seq_if.abort &&
        state_q inside {StUpStep, StUpDwell, StOn, StDnStep, StDnDwell}) begin
      power_en_d = '0;
      done_d     = 1'b0;
      err_code_d = ERR_ABORT;
      state_d    = StError;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      map_q      <= '0;
      visited_q  <= '0;
      power_en_q <= '0;
      order_q    <= '0;
      cur_q      <= '0;
      step_q     <= '0;
      done_q     <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      map_q      <= map_d;
      visited_q  <= visited_d;
      power_en_q <= power_en_d;
      order_q    <= order_d;
      cur_q      <= cur_d;
      step_q     <= step_d;
      done_q     <= done_d;
      err_code_q <= err_code_d;
    end
  end

  assign seq_if.power_en = power_en_q;
  assign seq_if.busy     = state_q inside {StUpStep, StUpDwell, StDnStep, StDnDwell};
  assign seq_if.done     = done_q;
  assign seq_if.err      = (state_q == StError);
  assign seq_if.err_code = err_code_q;
  assign seq_if.step_idx = step_q;

endmodule

// File: tb/tb_crystal_power_sequencer.sv
// Randomized scoreboard bench for the crystal power sequencer.
module tb_crystal_power_sequencer;
  import crystal_pkg::*;

  localparam int DC = 4;

  typedef struct packed {
    logic [7:0] pe;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] code;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } chg_t;

  localparam int FinIdle = 0, FinOn = 1, FinErr = 2;
  localparam int CutNone = 0, CutAbort = 1, CutReset = 2, CutRandAbort = 3;

  logic system_clk = 1'b0;
  logic rst_n      = 1'b0;
  int   cyc        = 0;

  crystal_power_sequencer_if seq_if ();

  crystal_power_sequencer #(
    .TIMER_W     (20),
    .DWELL_COUNT (20'(DC))
  ) dut (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .seq_if     (seq_if)
  );

  always #5 system_clk = ~system_clk;
  always @(posedge system_clk) cyc <= cyc + 1;

  chg_t       exp_q[$];
  chg_t       plan_q[$];
  logic [2:0] order[$];
  obs_t       last_exp = '0;
  obs_t       mon_prev = '0;
  bit         mon_en   = 1'b0;
  int         fin      = FinIdle;
  int         total    = 0;
  int         bad      = 0;

  function automatic obs_t sample();
    obs_t o;
    o.pe   = seq_if.power_en;
    o.busy = seq_if.busy;
    o.done = seq_if.done;
    o.err  = seq_if.err;
    o.code = seq_if.err_code;
    return o;
  endfunction

  // Monitor: every visible output change must match the next expected change and cycle.
  always @(negedge system_clk) begin : mon
    obs_t o;
    chg_t e;
    o = sample();
    if (mon_en && o !== mon_prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d actual pe=%h busy=%b done=%b err=%b code=%0d",
                 cyc, o.pe, o.busy, o.done, o.err, o.code);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v !== o) begin
          bad++;
          $display({"FAIL output_change actual cyc=%0d pe=%h busy=%b done=%b err=%b code=%0d",
                    " required cyc=%0d pe=%h busy=%b done=%b err=%b code=%0d"},
                   cyc, o.pe, o.busy, o.done, o.err, o.code,
                   e.cyc, e.v.pe, e.v.busy, e.v.done, e.v.err, e.v.code);
        end
      end
    end
    mon_prev = o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_plan(input int c, input obs_t o);
    chg_t e;
    e.cyc = c;
    e.v   = o;
    plan_q.push_back(e);
  endtask

  // Move the planned timeline into the scoreboard, dropping non-changes.
  task automatic commit();
    foreach (plan_q[i]) begin
      if (plan_q[i].v != last_exp) begin
        exp_q.push_back(plan_q[i]);
        last_exp = plan_q[i].v;
      end
    end
    plan_q.delete();
  endtask

  // An abort or reset seen at negedge 'at' replaces everything after it.
  task automatic cut(input int at, input int kind, inout int t_end, inout int f);
    chg_t keep[$];
    obs_t o;
    foreach (plan_q[i]) if (plan_q[i].cyc <= at) keep.push_back(plan_q[i]);
    plan_q = keep;
    o = '0;
    if (kind == CutAbort) begin
      o.err  = 1'b1;
      o.code = 3'd4;
      f      = FinErr;
    end else begin
      f = FinIdle;
    end
    push_plan(at + 1, o);
    t_end = at + 1;
  endtask

  // Reference: follow the chain rules, placing every output change on its cycle.
  task automatic model_up(input logic [31:0] map, input bit valid, input int c0,
                          output int t_end, output int f);
    obs_t       o;
    int         t;
    logic [7:0] vis;
    logic [2:0] cur;
    logic [3:0] nxt;
    o = '0;
    plan_q.delete();
    order.delete();
    t_end = c0 + 1;
    f     = FinErr;
    if (!valid) begin
      o.err  = 1'b1;
      o.code = 3'd1;
      push_plan(c0 + 1, o);
      return;
    end
    o.busy = 1'b1;
    push_plan(c0 + 1, o);
    vis = '0;
    cur = '0;
    t   = c0 + 1;
    for (int k = 0; k < 8; k++) begin
      if (vis[cur]) begin
        o      = '0;
        o.err  = 1'b1;
        o.code = 3'd3;
        push_plan(t + 1, o);
        t_end = t + 1;
        return;
      end
      vis[cur]  = 1'b1;
      o.pe[cur] = 1'b1;
      push_plan(t + 1, o);
      order.push_back(cur);
      nxt = map[4*cur +: 4];
      if (k == 7) begin
        o.busy = 1'b0;
        o.done = 1'b1;
        push_plan(t + 1 + DC, o);
        o.done = 1'b0;
        push_plan(t + 2 + DC, o);
        t_end = t + 1 + DC;
        f     = FinOn;
        return;
      end
      if (nxt[3]) begin
        o      = '0;
        o.err  = 1'b1;
        o.code = 3'd2;
        push_plan(t + 1 + DC, o);
        t_end = t + 1 + DC;
        return;
      end
      cur = nxt[2:0];
      t   = t + 1 + DC;
    end
  endtask

  task automatic model_down(input int s0, output int t_end, output int f);
    obs_t o;
    int   t;
    plan_q.delete();
    o      = '0;
    o.pe   = 8'hFF;
    o.busy = 1'b1;
    push_plan(s0 + 1, o);
    t     = s0 + 1;
    t_end = s0 + 1;
    f     = FinIdle;
    for (int k = 7; k >= 0; k--) begin
      o.pe[order[k]] = 1'b0;
      push_plan(t + 1, o);
      if (k == 0) begin
        o.busy = 1'b0;
        o.done = 1'b1;
        push_plan(t + 1 + DC, o);
        o.done = 1'b0;
        push_plan(t + 2 + DC, o);
        t_end = t + 1 + DC;
      end else begin
        t = t + 1 + DC;
      end
    end
  endtask

  task automatic quiet();
    seq_if.start     = 1'b0;
    seq_if.stop      = 1'b0;
    seq_if.abort     = 1'b0;
    seq_if.clear_err = 1'b0;
  endtask

  // Drive cycles until the sequence settles; noise is only applied where it must be ignored.
  task automatic drive(input int t_end, input bit noise, input int at, input int kind);
    bit in_rst;
    while (cyc < t_end + 4) begin
      @(negedge system_clk);
      in_rst           = (kind == CutReset) && cyc >= at && cyc <= at + 2;
      rst_n            = !in_rst;
      seq_if.start     = in_rst || (noise && cyc < t_end && $urandom_range(0, 3) == 0);
      seq_if.stop      = noise && cyc < t_end && $urandom_range(0, 3) == 0;
      seq_if.clear_err = noise && cyc < t_end && $urandom_range(0, 3) == 0;
      seq_if.abort     = (kind == CutAbort) && cyc == at;
      if (noise && cyc < t_end) begin
        seq_if.crystal_map = $urandom();
        seq_if.map_valid   = $urandom_range(0, 1) == 1;
      end
    end
    quiet();
  endtask

  task automatic do_up(input logic [31:0] map, input bit valid, input int kind_in,
                       input int off, input bit noise);
    int c0, t_end, f, at, kind;
    kind = kind_in;
    @(negedge system_clk);
    c0 = cyc;
    model_up(map, valid, c0, t_end, f);
    at = -1;
    if (kind == CutRandAbort) begin
      kind = CutNone;
      if (t_end >= c0 + 2) begin
        at   = $urandom_range(t_end - 1, c0 + 1);
        kind = CutAbort;
      end
    end else if (kind != CutNone) begin
      at = c0 + off;
    end
    if (kind != CutNone && at < t_end) cut(at, kind, t_end, f);
    else kind = CutNone;
    commit();
    seq_if.crystal_map = map;
    seq_if.map_valid   = valid;
    seq_if.start       = 1'b1;
    // Abort alongside start in IDLE is not sampled.
    seq_if.abort       = noise && $urandom_range(0, 1) == 1;
    drive(t_end, noise, at, kind);
    fin = f;
  endtask

  task automatic do_down(input int kind_in, input bit noise);
    int s0, t_end, f, at, kind;
    kind = CutNone;
    @(negedge system_clk);
    s0 = cyc;
    model_down(s0, t_end, f);
    at = -1;
    if (kind_in == CutRandAbort) begin
      at   = $urandom_range(t_end - 1, s0 + 1);
      kind = CutAbort;
      cut(at, kind, t_end, f);
    end
    commit();
    seq_if.stop = 1'b1;
    drive(t_end, noise, at, kind);
    fin = f;
  endtask

  task automatic do_on_abort();
    obs_t o;
    int   a;
    @(negedge system_clk);
    a      = cyc;
    o      = '0;
    o.err  = 1'b1;
    o.code = 3'd4;
    push_plan(a + 1, o);
    commit();
    seq_if.abort = 1'b1;
    drive(a + 1, 1'b0, -1, CutNone);
    fin = FinErr;
  endtask

  task automatic do_clear();
    int x;
    @(negedge system_clk);
    x = cyc;
    push_plan(x + 1, obs_t'('0));
    commit();
    seq_if.clear_err = 1'b1;
    // Start/stop alongside clear_err are ignored in ERROR.
    seq_if.start     = 1'b1;
    seq_if.stop      = 1'b1;
    drive(x + 1, 1'b0, -1, CutNone);
    fin = FinIdle;
  endtask

  function automatic logic [31:0] perm_map();
    logic [2:0]  p[8];
    logic [2:0]  tmp;
    logic [31:0] m;
    int          j;
    for (int i = 0; i < 8; i++) p[i] = 3'(i);
    for (int i = 7; i > 1; i--) begin
      j    = $urandom_range(i, 1);
      tmp  = p[i];
      p[i] = p[j];
      p[j] = tmp;
    end
    m = $urandom();
    for (int i = 0; i < 7; i++) m[4*p[i] +: 4] = {1'b0, p[i+1]};
    return m;
  endfunction

  function automatic logic [31:0] rand_map();
    logic [31:0] m;
    m = $urandom();
    for (int i = 0; i < 8; i++) if ($urandom_range(0, 7) != 0) m[4*i+3] = 1'b0;
    return m;
  endfunction

  initial begin : stim
    logic [31:0] m;
    int          r;
    bit          v;
    quiet();
    seq_if.map_valid   = 1'b0;
    seq_if.crystal_map = '0;
    repeat (3) @(negedge system_clk);
    check("reset_power_en", 32'(seq_if.power_en), 32'h0);
    check("reset_busy_done_err", {29'd0, seq_if.busy, seq_if.done, seq_if.err}, 32'h0);
    check("reset_err_code", 32'(seq_if.err_code), 32'h0);
    check("reset_step_idx", 32'(seq_if.step_idx), 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Linear chain up and down.
    for (int i = 0; i < 8; i++) m[4*i +: 4] = 4'((i + 1) % 8);
    do_up(m, 1'b1, CutNone, 0, 1'b0);
    do_down(CutNone, 1'b0);
    // Permuted chain 0-5-2-7-1-6-3-4.
    m = 32'h0;
    m[3:0] = 4'd5; m[23:20] = 4'd2; m[11:8] = 4'd7; m[31:28] = 4'd1;
    m[7:4] = 4'd6; m[27:24] = 4'd3; m[15:12] = 4'd4;
    do_up(m, 1'b1, CutNone, 0, 1'b0);
    do_down(CutNone, 1'b0);
    // Loop 0-1-0.
    do_up(32'h0000_0001, 1'b1, CutNone, 0, 1'b0);
    do_clear();
    // Broken first link.
    do_up(32'h0000_000F, 1'b1, CutNone, 0, 1'b0);
    do_clear();
    // No map.
    do_up(32'h0000_0001, 1'b0, CutNone, 0, 1'b0);
    do_clear();
    // Abort during step 3 dwell, abort while ON, reset mid power-up.
    for (int i = 0; i < 8; i++) m[4*i +: 4] = 4'((i + 1) % 8);
    do_up(m, 1'b1, CutAbort, 18, 1'b0);
    do_clear();
    do_up(m, 1'b1, CutNone, 0, 1'b0);
    do_on_abort();
    do_clear();
    do_up(m, 1'b1, CutReset, 12, 1'b0);

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      v = $urandom_range(0, 9) != 0;
      m = (r < 6) ? perm_map() : rand_map();
      do_up(m, v, ($urandom_range(0, 4) == 0) ? CutRandAbort : CutNone, 0, 1'b1);
      if (fin == FinOn) begin
        if ($urandom_range(0, 4) == 0) do_on_abort();
        else do_down(($urandom_range(0, 5) == 0) ? CutRandAbort : CutNone, 1'b1);
      end
      if (fin == FinErr) do_clear();
    end

    repeat (20) @(negedge system_clk);
    while (exp_q.size() > 0) begin
      chg_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_change actual=none required cyc=%0d pe=%h err=%b code=%0d",
               e.cyc, e.v.pe, e.v.err, e.v.code);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crystal_power_sequencer.md
Name: crystal_power_sequencer

Overview:
- Energizes the eight ship power crystals one at a time, in the chain order discovered by the crystal chain-probe block.
- Waits a programmable dwell between steps and de-energizes in exact reverse order on request.
- Detects broken or looping chain maps and aborts to a safe, all-off state.
- Sits between the crystal probe block (map source) and the ship power drivers (power_en sink).

Parameters:
- DWELL_COUNT, 20'd50000, cycles held after each enable/disable step before the next step (legal range is 1 or more).
- TIMER_W, 20, width of the dwell timer.

Ports:
- system_clk  in  1  system clock.
- rst_n  in  1  reset.
- start  in  1  begin power-up; sampled in IDLE only.
- stop  in  1  begin power-down; sampled in ON only.
- abort  in  1  emergency kill; sampled in all states except IDLE and ERROR.
- clear_err  in  1  leave ERROR.
- map_valid  in  1  crystal_map holds a completed probe result.
- crystal_map  in  32  crystal i "hooked up to" index at [4i+3:4i]; 4'hF marks a failed probe.
- power_en  out  8  per-crystal enable.
- busy  out  1  high in any state except IDLE, ON and ERROR.
- done  out  1  one-cycle pulse on completing power-up or power-down.
- err  out  1  high in ERROR.
- err_code  out  3  0 none, 1 NO_MAP, 2 BAD_MAP, 3 LOOP, 4 ABORT.
- step_idx  out  3  current sequence step.

Behaviour:
- Interface (already decided): one clock, system_clk; reset rst_n is synchronous and active-low.
- Reset values: all outputs 0; state IDLE; internal map copy, visited mask, order store and timer all cleared. Reset mid-sequence drops power_en to 0 at that edge.
- IDLE
  - start with map_valid=1: latch crystal_map internally; cur=0, step=0, visited=0; go to UP_STEP. Later changes to crystal_map are ignored.
  - start with map_valid=0: go to ERROR with code 1.
- UP_STEP (1 cycle)
  - If visited[cur] is set: go to ERROR with code 3.
  - Otherwise: set power_en[cur], set visited[cur], write order[step]=cur, clear timer, go to UP_DWELL.
- UP_DWELL
  - Increment timer each cycle until timer==DWELL_COUNT-1.
  - At that point, if step==7: go to ON and pulse done.
  - Otherwise let nxt = latched map[cur]. If nxt[3]=1: go to ERROR with code 2. Else cur=nxt[2:0], step+1, go to UP_STEP.
  - Consecutive enable edges are therefore DWELL_COUNT+1 cycles apart.
- ON
  - power_en==8'hFF is guaranteed, since 8 distinct visits cover all 8 crystals.
  - stop: go to DN_STEP with step=7.
- DN_STEP (1 cycle): clear power_en[order[step]], clear timer, go to DN_DWELL.
- DN_DWELL
  - Wait until timer==DWELL_COUNT-1.
  - If step==0: go to IDLE and pulse done. Otherwise step-1, go to DN_STEP.
- ERROR
  - power_en=0 from the edge of entry; err=1; err_code held.
  - clear_err: go to IDLE; err and err_code return to 0.
  - start and stop are ignored.
- abort
  - Has priority over every other input.
  - In UP_*, ON or DN_*: next edge sets power_en=0 and enters ERROR with code 4.
  - Ignored in IDLE and ERROR.
- Input gating: start is ignored outside IDLE; stop is ignored outside ON. Simultaneous start and abort in IDLE means start wins, because abort is not sampled in IDLE.
- Timer comparison uses TIMER_W bits and does not wrap in legal use.

Decomposition:
- Shared package crystal_pkg:
  - state encodings;
  - error codes (ERR_NONE, ERR_NO_MAP, ERR_BAD_MAP, ERR_LOOP, ERR_ABORT);
  - NUM_CRYSTALS=8;
  - CRYSTAL_BAD=4'hF, also used by the probe block.
- One natural sub-module: crystal_dwell_timer, a load/count/expire counter parameterized by DWELL_COUNT.

Test Plan (DWELL_COUNT=4):
1. Linear chain, map[i]=i+1 and map[7]=0, start → power_en steps 01,03,07,…,FF with rises 5 cycles apart; done pulses once on entering ON. Then stop → bits clear 7,6,…,0 at 5-cycle spacing, done pulses, returns to IDLE.
2. Permuted chain 0→5→2→7→1→6→3→4 → enables assert in that order; on stop they clear in order 4,3,6,1,7,2,5,0.
3. Loop map, map[0]=1 and map[1]=0 → bits 0 and 1 set, then ERROR with err_code=3 and power_en=0; clear_err → IDLE.
4. map[0]=4'hF → bit0 set, then after its dwell ERROR with err_code=2 and power_en=0.
5. start with map_valid=0 → next cycle err=1, err_code=1, power_en stays 0.
6. abort mid UP_DWELL at step 3 → next edge power_en=0, err_code=4. Separately, rst_n=0 mid-sequence → all outputs 0 at that edge; start then ignored until rst_n returns high.
